mem_ap_burst: RTL and testbench

// - Parametrised JTAG memory access point: drains a command FIFO and drives a generic bus.
// - Supports per-access transfer size, lane-correct byte enables and auto-increment bursts.
// - Returns read data through a response FIFO; reports alignment and size errors.
// - Sits between the JTAG-clock-crossing FIFOs (cmd in, rsp out) and the SoC generic bus master port.

---
 rtl/jtag_types_pkg.sv | 41 ++++
 rtl/mem_ap_lane_gen.sv | 52 +++++
 rtl/mem_ap_burst.sv | 168 ++++++++++++++++
 tb/tb_mem_ap_burst.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_types_pkg.sv
// Shared types for the JTAG access-port blocks:
// transfer sizes, command layout and memory-AP states.
package jtag_types_pkg;

    localparam int AP_ADDR_W = 32;
    localparam int AP_DATA_W = 32;
    localparam int AP_CNT_W  = 5;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } ap_size_t;

    typedef struct packed {
        logic [AP_DATA_W-1:0] data;
        logic                 reg_sel;
        ap_size_t             size;
        logic [AP_CNT_W-1:0]  count;
        logic                 rw;
    } ap_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RSP,
        WR,
        WDAT
    } mem_ap_state_t;

    function automatic logic [2:0] ap_incr(input ap_size_t s);
        case (s)
            SZ_BYTE: ap_incr = 3'd1;
            SZ_HALF: ap_incr = 3'd2;
            SZ_WORD: ap_incr = 3'd4;
            default: ap_incr = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_ap_lane_gen.sv
// Size/address lane decode: byte enables, replicated
// write data, address step and misalignment flag.
module mem_ap_lane_gen
    import jtag_types_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]                  i_size,
    input  logic [$clog2(DATA_W/8)-1:0] i_addr_lo,
    input  logic [DATA_W-1:0]           i_data,
    output logic [DATA_W/8-1:0]         o_byte_en,
    output logic [DATA_W-1:0]           o_wdata,
    output logic [2:0]                  o_incr,
    output logic                        o_misalign
);

    localparam int BE_W = DATA_W / 8;
    localparam int LO_W = $clog2(BE_W);

    ap_size_t w_size;

    assign w_size = ap_size_t'(i_size);

    always_comb begin
        o_byte_en  = '0;
        o_wdata    = i_data;
        o_misalign = 1'b0;
        o_incr     = ap_incr(w_size);
        case (w_size)
            SZ_BYTE: begin
                o_byte_en = BE_W'(1) << i_addr_lo;
                for (int i = 0; i < BE_W; i++)
                    o_wdata[8*i +: 8] = i_data[7:0];
            end
            SZ_HALF: begin
                // Low address bit ignored for the shift; it only flags misalignment.
                o_byte_en = BE_W'(3) << (i_addr_lo & ~LO_W'(1));
                for (int i = 0; i < BE_W/2; i++)
                    o_wdata[16*i +: 16] = i_data[15:0];
                o_misalign = i_addr_lo[0];
            end
            SZ_WORD: begin
                o_byte_en = BE_W'(15) << (i_addr_lo & ~LO_W'(3));
                for (int i = 0; i < BE_W/4; i++)
                    o_wdata[32*i +: 32] = i_data[31:0];
                o_misalign = |i_addr_lo[1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_ap_burst.sv
// JTAG memory access point: drains the command FIFO, runs
// sized single/burst accesses on the bus, returns read data.
module mem_ap_burst
    import jtag_types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic                    AFT_CLK,
    input  logic                    TRST,
    input  logic [DATA_W+CNT_W+3:0] cmd_rdata,
    input  logic                    cmd_rempty,
    output logic                    cmd_rinc,
    output logic [DATA_W-1:0]       rsp_wdata,
    input  logic                    rsp_wfull,
    output logic                    rsp_winc,
    output logic [ADDR_W-1:0]       bus_addr,
    output logic [DATA_W-1:0]       bus_wdata,
    output logic [DATA_W/8-1:0]     bus_byte_en,
    output logic                    bus_ren,
    output logic                    bus_wen,
    input  logic [DATA_W-1:0]       bus_rdata,
    input  logic                    bus_busy,
    output logic                    err,
    input  logic                    err_clr,
    output logic                    ap_busy
);

    localparam int BE_W = DATA_W / 8;
    localparam int LO_W = $clog2(BE_W);

    mem_ap_state_t r_state, w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_rdata;
    logic [CNT_W-1:0]  r_cnt;
    ap_size_t          r_size;
    logic              r_err;

    logic              w_cmd_rw;
    logic [CNT_W-1:0]  w_cmd_cnt;
    ap_size_t          w_cmd_size;
    logic              w_cmd_sel;
    logic [DATA_W-1:0] w_cmd_data;

    logic              w_ld_addr, w_ld_cmd, w_ld_data;
    logic              w_cap, w_adv, w_set_err;
    logic [1:0]        w_lg_size;
    logic [BE_W-1:0]   w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [2:0]        w_incr;
    logic              w_misalign;

    assign w_cmd_rw   = cmd_rdata[0];
    assign w_cmd_cnt  = cmd_rdata[CNT_W:1];
    assign w_cmd_size = ap_size_t'(cmd_rdata[CNT_W+2:CNT_W+1]);
    assign w_cmd_sel  = cmd_rdata[CNT_W+3];
    assign w_cmd_data = cmd_rdata[CNT_W+4 +: DATA_W];

    // In IDLE the decoder checks the incoming command against the current address.
    assign w_lg_size = (r_state == IDLE) ? w_cmd_size : r_size;

    mem_ap_lane_gen #(.DATA_W(DATA_W)) u_lane (
        .i_size     (w_lg_size),
        .i_addr_lo  (r_addr[LO_W-1:0]),
        .i_data     (r_data),
        .o_byte_en  (w_be),
        .o_wdata    (w_wdata),
        .o_incr     (w_incr),
        .o_misalign (w_misalign)
    );

    always_ff @(posedge AFT_CLK or negedge TRST) begin
        if (!TRST) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        cmd_rinc  = 1'b0;
        rsp_winc  = 1'b0;
        bus_ren   = 1'b0;
        bus_wen   = 1'b0;
        w_ld_addr = 1'b0;
        w_ld_cmd  = 1'b0;
        w_ld_data = 1'b0;
        w_cap     = 1'b0;
        w_adv     = 1'b0;
        w_set_err = 1'b0;
        unique case (r_state)
            IDLE: if (!cmd_rempty) begin
                cmd_rinc = 1'b1;
                if (!w_cmd_sel) begin
                    w_ld_addr = 1'b1;
                end else if (w_cmd_size == SZ_RSVD || w_misalign) begin
                    w_set_err = 1'b1;
                end else begin
                    w_ld_cmd = 1'b1;
                    w_next   = w_cmd_rw ? WR : RD;
                end
            end
            RD: begin
                bus_ren = 1'b1;
                if (!bus_busy) begin
                    w_cap  = 1'b1;
                    w_next = RSP;
                end
            end
            RSP: if (!rsp_wfull) begin
                rsp_winc = 1'b1;
                if (r_cnt != '0) begin
                    w_adv  = 1'b1;
                    w_next = RD;
                end else begin
                    w_next = IDLE;
                end
            end
            WR: begin
                bus_wen = 1'b1;
                if (!bus_busy) begin
                    w_adv  = 1'b1;
                    w_next = (r_cnt != '0) ? WDAT : IDLE;
                end
            end
            WDAT: if (!cmd_rempty) begin
                cmd_rinc  = 1'b1;
                w_ld_data = 1'b1;
                w_next    = WR;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge AFT_CLK or negedge TRST) begin
        if (!TRST) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_size  <= SZ_BYTE;
            r_err   <= 1'b0;
        end else begin
            if (w_ld_addr)  r_addr <= w_cmd_data[ADDR_W-1:0];
            else if (w_adv) r_addr <= r_addr + ADDR_W'(w_incr);
            if (w_ld_cmd) begin
                r_size <= w_cmd_size;
                r_cnt  <= w_cmd_cnt;
                if (w_cmd_rw) r_data <= w_cmd_data;
            end else if (w_adv && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_ld_data) r_data  <= w_cmd_data;
            if (w_cap)     r_rdata <= bus_rdata;
            if (w_set_err)    r_err <= 1'b1;
            else if (err_clr) r_err <= 1'b0;
        end
    end

    assign bus_addr    = r_addr;
    assign bus_wdata   = w_wdata;
    assign bus_byte_en = (bus_ren || bus_wen) ? w_be : '0;
    assign rsp_wdata   = r_rdata;
    assign err         = r_err;
    assign ap_busy     = (r_state != IDLE);

endmodule

// File: tb/tb_mem_ap_burst.sv
// Bench for mem_ap_burst: FIFO/bus models, a transaction-level
// expectation queue checked every cycle, plus literal spot checks.
module tb_mem_ap_burst;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int CW   = 5;
    localparam int CMDW = DW + CW + 4;

    logic            AFT_CLK, TRST;
    logic [CMDW-1:0] cmd_rdata;
    logic            cmd_rempty, cmd_rinc;
    logic [DW-1:0]   rsp_wdata;
    logic            rsp_wfull, rsp_winc;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_wdata;
    logic [3:0]      bus_byte_en;
    logic            bus_ren, bus_wen;
    logic [DW-1:0]   bus_rdata;
    logic            bus_busy;
    logic            err, err_clr, ap_busy;

    mem_ap_burst #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .AFT_CLK     (AFT_CLK),
        .TRST        (TRST),
        .cmd_rdata   (cmd_rdata),
        .cmd_rempty  (cmd_rempty),
        .cmd_rinc    (cmd_rinc),
        .rsp_wdata   (rsp_wdata),
        .rsp_wfull   (rsp_wfull),
        .rsp_winc    (rsp_winc),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_byte_en (bus_byte_en),
        .bus_ren     (bus_ren),
        .bus_wen     (bus_wen),
        .bus_rdata   (bus_rdata),
        .bus_busy    (bus_busy),
        .err         (err),
        .err_clr     (err_clr),
        .ap_busy     (ap_busy)
    );

    typedef struct {
        bit          rw;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } txn_t;

    typedef struct {
        bit          rw;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          start;
        int          held;
    } log_t;

    logic [CMDW-1:0] cmdq[$];
    txn_t            expq[$];
    logic [31:0]     rspq[$];
    logic [31:0]     wq[$];
    log_t            blog[$];
    logic [31:0]     rlog[$];
    int              rcyc[$];

    int          checks, failures, cyc, last_pop, held, busy_left, full_left;
    bit          pop_pend, arm_full, fixed_en;
    logic [31:0] fixed_val;

    initial begin
        AFT_CLK = 1'b0;
        forever #5 AFT_CLK = ~AFT_CLK;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [3:0] be_of(input logic [31:0] a, input logic [1:0] sz);
        case (sz)
            2'd0:    return 4'b0001 << a[1:0];
            2'd1:    return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] rep_of(input logic [31:0] d, input logic [1:0] sz);
        case (sz)
            2'd0:    return {4{d[7:0]}};
            2'd1:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [CMDW-1:0] mk(input logic [31:0] d, input logic sel,
                                           input logic [1:0] sz, input logic [4:0] c,
                                           input logic rw);
        return {d, sel, sz, c, rw};
    endfunction

    // Expected beats of a burst: address steps by the access size, wrapping at 2^32.
    task automatic model_burst(input bit rw, input logic [31:0] base,
                               input logic [1:0] sz, input int n);
        txn_t e;
        logic [31:0] a;
        a = base;
        for (int k = 0; k < n; k++) begin
            e.rw   = rw;
            e.addr = a;
            e.be   = be_of(a, sz);
            e.wd   = rw ? rep_of(wq[k], sz) : 32'h0;
            expq.push_back(e);
            if (!rw) rspq.push_back(fixed_en ? fixed_val : rd_fn(a));
            a = a + (32'd1 << sz);
        end
    endtask

    always_comb bus_rdata = fixed_en ? fixed_val : rd_fn(bus_addr);

    always @(posedge AFT_CLK) begin
        #1;
        if (pop_pend) begin
            if (cmdq.size() > 0) void'(cmdq.pop_front());
            pop_pend = 1'b0;
        end
        cmd_rempty = (cmdq.size() == 0);
        if (cmdq.size() > 0) cmd_rdata = cmdq[0];
        else                 cmd_rdata = '0;
        bus_busy  = (busy_left != 0);
        rsp_wfull = (full_left != 0);
    end

    always @(negedge AFT_CLK) begin
        txn_t e;
        log_t l;
        cyc++;
        if (full_left > 0) full_left--;
        if (TRST) begin
            if (cmd_rinc) begin
                pop_pend = 1'b1;
                last_pop = cyc;
            end
            if (bus_ren || bus_wen) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req addr=%0h ren=%0b wen=%0b required=none",
                             bus_addr, bus_ren, bus_wen);
                end else begin
                    e = expq[0];
                    chk("req_rw", bus_wen, e.rw);
                    chk("req_ren", bus_ren, !e.rw);
                    chk("req_addr", bus_addr, e.addr);
                    chk("req_be", bus_byte_en, e.be);
                    if (e.rw) chk("req_wdata", bus_wdata, e.wd);
                    if (!bus_busy) begin
                        l.rw = e.rw; l.addr = bus_addr; l.be = bus_byte_en;
                        l.wd = bus_wdata; l.start = cyc - held; l.held = held + 1;
                        blog.push_back(l);
                        void'(expq.pop_front());
                        held = 0;
                    end else begin
                        held++;
                    end
                end
                if (bus_busy && busy_left > 0) busy_left--;
            end
            if (rsp_winc) begin
                chk("rsp_not_full", rsp_wfull, 1'b0);
                if (rspq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp data=%0h required=none", rsp_wdata);
                end else begin
                    chk("rsp_data", rsp_wdata, rspq[0]);
                    void'(rspq.pop_front());
                end
                rlog.push_back(rsp_wdata);
                rcyc.push_back(cyc);
                if (arm_full) begin
                    full_left = 5;
                    arm_full  = 1'b0;
                end
            end
        end
    end

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge AFT_CLK);
            #1;
            if (cmdq.size() == 0 && expq.size() == 0 && rspq.size() == 0 &&
                !ap_busy && !pop_pend) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, ok, 1'b1);
    endtask

    task automatic clr_logs();
        blog.delete();
        rlog.delete();
        rcyc.delete();
        wq.delete();
    endtask

    task automatic chk_outs_zero(input string nm);
        chk({nm, "_ren"}, bus_ren, 1'b0);
        chk({nm, "_wen"}, bus_wen, 1'b0);
        chk({nm, "_rinc"}, cmd_rinc, 1'b0);
        chk({nm, "_winc"}, rsp_winc, 1'b0);
        chk({nm, "_addr"}, bus_addr, 32'h0);
        chk({nm, "_wdata"}, bus_wdata, 32'h0);
        chk({nm, "_be"}, bus_byte_en, 4'h0);
        chk({nm, "_rdata"}, rsp_wdata, 32'h0);
        chk({nm, "_err"}, err, 1'b0);
        chk({nm, "_busy"}, ap_busy, 1'b0);
    endtask

    initial begin
        bit seen;
        checks = 0; failures = 0; cyc = 0; last_pop = 0; held = 0;
        busy_left = 0; full_left = 0; pop_pend = 0; arm_full = 0;
        fixed_en = 0; fixed_val = 32'h0;
        TRST = 1'b0; cmd_rempty = 1'b1; cmd_rdata = '0;
        rsp_wfull = 1'b0; bus_busy = 1'b0; err_clr = 1'b0;

        repeat (3) @(negedge AFT_CLK);
        chk_outs_zero("rst");
        TRST = 1'b1;

        // Single word read
        @(negedge AFT_CLK);
        clr_logs();
        fixed_en = 1'b1; fixed_val = 32'hDEADBEEF;
        cmdq.push_back(mk(32'h1000, 0, 2'd0, 5'd0, 0));
        cmdq.push_back(mk(32'h0, 1, 2'd2, 5'd0, 0));
        model_burst(0, 32'h1000, 2'd2, 1);
        wait_idle("t1_done");
        fixed_en = 1'b0;
        chk("t1_nreq", blog.size(), 1);
        chk("t1_nrsp", rlog.size(), 1);
        if (blog.size() > 0) begin
            chk("t1_addr", blog[0].addr, 32'h1000);
            chk("t1_be", blog[0].be, 4'b1111);
            chk("t1_ren_lat", blog[0].start, last_pop + 1);
        end
        if (rlog.size() > 0) begin
            chk("t1_rsp", rlog[0], 32'hDEADBEEF);
            chk("t1_rsp_lat", rcyc[0], last_pop + 2);
        end

        // Byte write burst with lane walk across the word boundary
        clr_logs();
        wq = '{32'hAA, 32'hBB, 32'hCC, 32'hDD};
        cmdq.push_back(mk(32'h2001, 0, 2'd0, 5'd0, 0));
        cmdq.push_back(mk(32'hAA, 1, 2'd0, 5'd3, 1));
        cmdq.push_back(mk(32'hBB, 0, 2'd3, 5'd31, 0));
        cmdq.push_back(mk(32'hCC, 0, 2'd3, 5'd31, 0));
        cmdq.push_back(mk(32'hDD, 0, 2'd3, 5'd31, 0));
        model_burst(1, 32'h2001, 2'd0, 4);
        wait_idle("t2_done");
        chk("t2_nreq", blog.size(), 4);
        if (blog.size() == 4) begin
            chk("t2_be0", blog[0].be, 4'b0010);
            chk("t2_be1", blog[1].be, 4'b0100);
            chk("t2_be2", blog[2].be, 4'b1000);
            chk("t2_be3", blog[3].be, 4'b0001);
            chk("t2_addr3", blog[3].addr, 32'h2004);
            chk("t2_wd1", blog[1].wd, 32'hBBBBBBBB);
        end

        // Read burst with response FIFO full on the second beat
        clr_logs();
        cmdq.push_back(mk(32'h3000, 0, 2'd0, 5'd0, 0));
        cmdq.push_back(mk(32'h0, 1, 2'd2, 5'd2, 0));
        arm_full = 1'b1;
        model_burst(0, 32'h3000, 2'd2, 3);
        wait_idle("t3_done");
        chk("t3_npush", rlog.size(), 3);
        if (rlog.size() == 3) begin
            chk("t3_rsp1", rlog[1], 32'h3004CFFB);
            chk("t3_gap01", rcyc[1] - rcyc[0], 6);
            chk("t3_gap12", rcyc[2] - rcyc[1], 2);
        end

        // Misaligned word read sets err; following command still runs
        clr_logs();
        cmdq.push_back(mk(32'h1002, 0, 2'd0, 5'd0, 0));
        cmdq.push_back(mk(32'h0, 1, 2'd2, 5'd0, 0));
        cmdq.push_back(mk(32'h0, 1, 2'd1, 5'd0, 0));
        model_burst(0, 32'h1002, 2'd1, 1);
        wait_idle("t4_done");
        chk("t4_err_set", err, 1'b1);
        chk("t4_nreq", blog.size(), 1);
        if (blog.size() > 0) chk("t4_be", blog[0].be, 4'b1100);
        err_clr = 1'b1;
        @(negedge AFT_CLK);
        err_clr = 1'b0;
        chk("t4_err_clr", err, 1'b0);
        cmdq.push_back(mk(32'h0, 1, 2'd3, 5'd0, 0));
        @(negedge AFT_CLK);
        chk("t4_pop_now", cmd_rinc, 1'b1);
        err_clr = 1'b1;
        @(negedge AFT_CLK);
        err_clr = 1'b0;
        chk("t4_set_wins", err, 1'b1);
        err_clr = 1'b1;
        @(negedge AFT_CLK);
        err_clr = 1'b0;
        chk("t4_err_clr2", err, 1'b0);
        wait_idle("t4_idle");

        // Write held off by bus_busy for 4 cycles
        clr_logs();
        wq = '{32'h12345678};
        busy_left = 4;
        cmdq.push_back(mk(32'h4000, 0, 2'd0, 5'd0, 0));
        cmdq.push_back(mk(32'h12345678, 1, 2'd2, 5'd0, 1));
        model_burst(1, 32'h4000, 2'd2, 1);
        wait_idle("t5_done");
        chk("t5_nreq", blog.size(), 1);
        if (blog.size() > 0) begin
            chk("t5_held", blog[0].held, 5);
            chk("t5_wen_lat", blog[0].start, last_pop + 1);
            chk("t5_wd", blog[0].wd, 32'h12345678);
        end

        // Halfword write burst
        clr_logs();
        wq = '{32'h0000BEEF, 32'h0000CAFE};
        cmdq.push_back(mk(32'h5002, 0, 2'd0, 5'd0, 0));
        cmdq.push_back(mk(32'h0000BEEF, 1, 2'd1, 5'd1, 1));
        cmdq.push_back(mk(32'h0000CAFE, 1, 2'd0, 5'd0, 1));
        model_burst(1, 32'h5002, 2'd1, 2);
        wait_idle("t6_done");
        chk("t6_nreq", blog.size(), 2);
        if (blog.size() == 2) begin
            chk("t6_be0", blog[0].be, 4'b1100);
            chk("t6_wd0", blog[0].wd, 32'hBEEFBEEF);
            chk("t6_addr1", blog[1].addr, 32'h5004);
            chk("t6_be1", blog[1].be, 4'b0011);
            chk("t6_wd1", blog[1].wd, 32'hCAFECAFE);
        end

        // Address wrap at the top of the map
        clr_logs();
        cmdq.push_back(mk(32'hFFFFFFFC, 0, 2'd0, 5'd0, 0));
        cmdq.push_back(mk(32'h0, 1, 2'd2, 5'd1, 0));
        model_burst(0, 32'hFFFFFFFC, 2'd2, 2);
        wait_idle("t7_done");
        chk("t7_nreq", blog.size(), 2);
        if (blog.size() == 2) begin
            chk("t7_addr0", blog[0].addr, 32'hFFFFFFFC);
            chk("t7_addr1", blog[1].addr, 32'h0);
        end

        // TRST in the middle of a stalled read burst
        clr_logs();
        busy_left = 50;
        cmdq.push_back(mk(32'h6000, 0, 2'd0, 5'd0, 0));
        cmdq.push_back(mk(32'h0, 1, 2'd2, 5'd3, 0));
        model_burst(0, 32'h6000, 2'd2, 4);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge AFT_CLK);
            if (bus_ren) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t8_ren_seen", seen, 1'b1);
        #2;
        TRST = 1'b0;
        #1;
        chk_outs_zero("t8");
        cmdq.delete(); expq.delete(); rspq.delete();
        pop_pend = 1'b0; busy_left = 0; held = 0; arm_full = 1'b0;
        repeat (2) @(negedge AFT_CLK);
        TRST = 1'b1;
        blog.delete();
        repeat (6) @(negedge AFT_CLK);
        chk("t8_no_strobes", blog.size(), 0);
        chk("t8_idle", ap_busy, 1'b0);

        // Recovery after reset
        clr_logs();
        cmdq.push_back(mk(32'h7003, 0, 2'd0, 5'd0, 0));
        cmdq.push_back(mk(32'h0, 1, 2'd0, 5'd0, 0));
        model_burst(0, 32'h7003, 2'd0, 1);
        wait_idle("t9_done");
        chk("t9_nreq", blog.size(), 1);
        if (blog.size() > 0) chk("t9_be", blog[0].be, 4'b1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
